input_deser_align: RTL

Serial-to-parallel input deserializer with word alignment. It sits directly downstream of the SP-enabled input capture register: its D/SP inputs take that register's Q output and the same bit-valid enable. It packs WIDTH qualified bits MSB-first into a parallel word, emits a one-cycle valid strobe per word, and shifts the word boundary one bit per bitslip request. An optional training-pattern auto-aligner can be compiled in.

---
 rtl/input_deser_align.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/input_deser_align.sv
// Serial-to-parallel input deserializer with bitslip word alignment.
//
// Packs WIDTH bits, qualified by SP, MSB-first into a parallel word. The first
// received bit ends up in Q[WIDTH-1]. A rising edge on SLIP moves the word
// boundary one bit later: the next qualified bit is shifted in without
// advancing the bit counter.
//
// Optional feature, enabled by defining IDESER_AUTOALIGN_EN: a training-pattern
// aligner. It keeps issuing slips until a compared word equals
// SYNC_PAT[WIDTH-1:0], and then raises LOCK.
//
// Ports:
//   SCLK    - clock; all state changes on the rising edge
//   CDN     - asynchronous active-low reset
//   D       - serial data bit from the upstream capture register
//   SP      - bit qualifier; D is consumed only when SP=1
//   SLIP    - bitslip request (level or pulse; rising edge detected)
//   Q       - parallel word, first-received bit in Q[WIDTH-1]
//   QV      - one-cycle strobe, Q is new
//   SLIPACK - one-cycle strobe, a slip was applied
//   LOCK    - aligner locked (tied 0 without IDESER_AUTOALIGN_EN)

module input_deser_align #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [7:0]  SYNC_PAT = 8'hA5
) (
  input  logic             SCLK,
  input  logic             CDN,
  input  logic             D,
  input  logic             SP,
  input  logic             SLIP,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             SLIPACK,
  output logic             LOCK
);

  localparam int unsigned    CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StPend, StHold} slip_st_e;

  slip_st_e         slip_st_q, slip_st_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             qv_q, qv_d;
  logic             ack_q, ack_d;
  logic             slip_q;
  logic             ext_req;
  logic             slip_req;
  logic             apply;
  logic             emit;

  assign ext_req = SLIP & ~slip_q;

  // A word completes on the last counted bit, unless that bit is the slipped one.
  assign emit = SP & (cnt_q == CntMax) & ~apply;

  // Datapath
  always_ff @(posedge SCLK or negedge CDN) begin
    if (!CDN) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      qv_q   <= 1'b0;
      ack_q  <= 1'b0;
      slip_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      qv_q   <= qv_d;
      ack_q  <= ack_d;
      slip_q <= SLIP;
    end
  end

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    if (SP) begin
      sh_d = {sh_q[WIDTH-2:0], D};
      if (!apply) begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end
    end
    if (emit) begin
      q_d = {sh_q[WIDTH-2:0], D};
    end
    qv_d  = emit;
    ack_d = apply;
  end

  // Slip FSM: state register
  always_ff @(posedge SCLK or negedge CDN) begin
    if (!CDN) begin
      slip_st_q <= StIdle;
    end else begin
      slip_st_q <= slip_st_d;
    end
  end

  // Slip FSM: next state. Requests seen outside StIdle are dropped.
  always_comb begin
    slip_st_d = slip_st_q;
    unique case (slip_st_q)
      StIdle: if (slip_req) slip_st_d = StPend;
      StPend: if (SP)       slip_st_d = StHold;
      StHold: if (emit)     slip_st_d = StIdle;
      default:              slip_st_d = StIdle;
    endcase
  end

  // Slip FSM: outputs
  always_comb begin
    apply = (slip_st_q == StPend) & SP;
  end

`ifdef IDESER_AUTOALIGN_EN
  typedef enum logic {StSearch, StLocked} align_st_e;

  align_st_e align_st_q, align_st_d;
  logic      lock_q;
  logic      skip_q;
  logic      cmp_en;
  logic      match;

  // The word that completes while the slip FSM is in StHold straddles the slip.
  // It is flagged here so the aligner does not judge alignment from it.
  always_ff @(posedge SCLK or negedge CDN) begin
    if (!CDN) begin
      align_st_q <= StSearch;
      lock_q     <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      align_st_q <= align_st_d;
      lock_q     <= (align_st_d == StLocked);
      skip_q     <= emit & (slip_st_q == StHold);
    end
  end

  assign cmp_en = qv_q & ~skip_q & (slip_st_q == StIdle) & (align_st_q == StSearch);
  assign match  = (q_q == SYNC_PAT[WIDTH-1:0]);

  always_comb begin
    align_st_d = align_st_q;
    unique case (align_st_q)
      StSearch: if (cmp_en && match) align_st_d = StLocked;
      StLocked: if (ext_req)         align_st_d = StSearch;
      default:                       align_st_d = StSearch;
    endcase
  end

  // While locked, an external request only drops lock; it never slips.
  assign slip_req = (align_st_q == StSearch) & (ext_req | (cmp_en & ~match));
  assign LOCK     = lock_q;

  logic unused_sh;
  assign unused_sh = sh_q[WIDTH-1];
`else
  assign slip_req = ext_req;
  assign LOCK     = 1'b0;

  logic unused_sh;
  assign unused_sh = sh_q[WIDTH-1] ^ (^SYNC_PAT);
`endif

  assign Q       = q_q;
  assign QV      = qv_q;
  assign SLIPACK = ack_q;

endmodule
